// File: rtl/alu_src_b_pkg.sv
// Shared select codes and buffer-occupancy state for the ALU operand-B stage.
package alu_src_b_pkg;

  localparam int unsigned SEL_W = 3;

  localparam logic [SEL_W-1:0] SEL_B    = 3'd0;
  localparam logic [SEL_W-1:0] SEL_INC  = 3'd1;
  localparam logic [SEL_W-1:0] SEL_LUI  = 3'd2;
  localparam logic [SEL_W-1:0] SEL_BR   = 3'd3;
  localparam logic [SEL_W-1:0] SEL_SEXT = 3'd4;
  localparam logic [SEL_W-1:0] SEL_ZEXT = 3'd5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

endpackage

// File: rtl/alu_src_b_sel.sv
// Combinational operand-B mux with immediate transforms and illegal-select flag.
// Optional forwarding of select 0 is enabled by ALU_SRC_B_FWD_EN.
module alu_src_b_sel
  import alu_src_b_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IMM_W = 16,
  parameter int unsigned INC   = 4
) (
  input  logic [SEL_W-1:0] sel,
  input  logic [WIDTH-1:0] b_in,
  input  logic [IMM_W-1:0] imm,
`ifdef ALU_SRC_B_FWD_EN
  input  logic             fwd_valid,
  input  logic [WIDTH-1:0] fwd_data,
`endif
  output logic [WIDTH-1:0] result_c,
  output logic             illegal_c
);

  logic [WIDTH-1:0] sext;
  logic [WIDTH-1:0] b_src;

  assign sext = {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm};

`ifdef ALU_SRC_B_FWD_EN
  assign b_src = fwd_valid ? fwd_data : b_in;
`else
  assign b_src = b_in;
`endif

  // Codes 6 and 7 fall into default: operand zero, flagged illegal.
  always_comb begin
    result_c  = '0;
    illegal_c = 1'b0;
    case (sel)
      SEL_B:    result_c = b_src;
      SEL_INC:  result_c = WIDTH'(INC);
      SEL_LUI:  result_c = WIDTH'({imm, 16'h0000});
      SEL_BR:   result_c = sext << 2;
      SEL_SEXT: result_c = sext;
      SEL_ZEXT: result_c = WIDTH'(imm);
      default:  illegal_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_src_b_stage.sv
// Registered operand-B select feeding the ALU through a two-entry skid buffer.
// Define ALU_SRC_B_FWD_EN to add the fwd_valid/fwd_data forwarding ports.
module alu_src_b_stage
  import alu_src_b_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IMM_W = 16,
  parameter int unsigned INC   = 4,
  parameter int unsigned ERR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] sel,
  input  logic [WIDTH-1:0] b_in,
  input  logic [IMM_W-1:0] imm,
`ifdef ALU_SRC_B_FWD_EN
  input  logic             fwd_valid,
  input  logic [WIDTH-1:0] fwd_data,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] operand,
  output logic             sel_err,
  output logic [ERR_W-1:0] err_cnt
);

  occ_t             state, state_nxt;
  logic [WIDTH-1:0] new_op;
  logic             new_err;
  logic [WIDTH-1:0] skid_op;
  logic             skid_err;
  logic             acc, pop;
  logic             head_ld, head_from_skid, skid_ld;

  alu_src_b_sel #(
    .WIDTH (WIDTH),
    .IMM_W (IMM_W),
    .INC   (INC)
  ) u_sel (
    .sel       (sel),
    .b_in      (b_in),
    .imm       (imm),
`ifdef ALU_SRC_B_FWD_EN
    .fwd_valid (fwd_valid),
    .fwd_data  (fwd_data),
`endif
    .result_c  (new_op),
    .illegal_c (new_err)
  );

  assign acc = in_valid && in_ready;
  assign pop = out_valid && out_ready;

  // Occupancy next-state and buffer load controls.
  always_comb begin
    state_nxt      = state;
    head_ld        = 1'b0;
    head_from_skid = 1'b0;
    skid_ld        = 1'b0;
    case (state)
      EMPTY: begin
        if (acc) begin
          state_nxt = ONE;
          head_ld   = 1'b1;
        end
      end
      ONE: begin
        if (acc && pop) begin
          head_ld = 1'b1;
        end else if (acc) begin
          state_nxt = TWO;
          skid_ld   = 1'b1;
        end else if (pop) begin
          state_nxt = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          state_nxt      = ONE;
          head_from_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Handshake flags are registered decodes of the next occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      operand   <= '0;
      sel_err   <= 1'b0;
      skid_op   <= '0;
      skid_err  <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt != TWO);
      out_valid <= (state_nxt != EMPTY);
      if (head_ld) begin
        operand <= new_op;
        sel_err <= new_err;
      end else if (head_from_skid) begin
        operand <= skid_op;
        sel_err <= skid_err;
      end
      if (skid_ld) begin
        skid_op  <= new_op;
        skid_err <= new_err;
      end
      if (acc && new_err && (err_cnt != '1)) begin
        err_cnt <= err_cnt + ERR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_src_b_stage.sv
// Scoreboard bench for alu_src_b_stage: driver pushes expected operands, monitor pops on output handshakes.
module tb_alu_src_b_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  sel = 3'd0;
  logic [31:0] b_in = 32'd0;
  logic [15:0] imm = 16'd0;
`ifdef ALU_SRC_B_FWD_EN
  logic        fwd_valid = 1'b0;
  logic [31:0] fwd_data = 32'd0;
`endif
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] operand;
  logic        sel_err;
  logic [7:0]  err_cnt;

  typedef struct {
    logic [31:0] op;
    logic        err;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   model_cnt = 0;
  int   ready_mode = 1;

  alu_src_b_stage dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .b_in      (b_in),
    .imm       (imm),
`ifdef ALU_SRC_B_FWD_EN
    .fwd_valid (fwd_valid),
    .fwd_data  (fwd_data),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .operand   (operand),
    .sel_err   (sel_err),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: operand value from the select rules using integer arithmetic.
  function automatic logic [31:0] model(input logic [2:0] s, input logic [31:0] b,
                                        input logic [15:0] im, input logic fv,
                                        input logic [31:0] fd);
    longint v;
    v = longint'(im);
    if (v >= 32768) v = v - 65536;
    case (s)
      3'd0:    return fv ? fd : b;
      3'd1:    return 32'd4;
      3'd2:    return 32'(longint'(im) * 65536);
      3'd3:    return 32'(v * 4);
      3'd4:    return 32'(v);
      3'd5:    return 32'(longint'(im));
      default: return 32'd0;
    endcase
  endfunction

  // out_ready policy: 0 hold low, 1 hold high, 2 random.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: occupancy flags, counter, and in-order operand check.
  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_operand", 64'(operand), 64'd0);
      chk("rst_sel_err", 64'(sel_err), 64'd0);
      chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    end else begin
      chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
      chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
      chk("err_cnt", 64'(err_cnt), 64'(model_cnt));
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("pop_unexpected", 64'd1, 64'd0);
        end else begin
          mon_e = q.pop_front();
          chk("operand", 64'(operand), 64'(mon_e.op));
          chk("sel_err", 64'(sel_err), 64'(mon_e.err));
        end
      end
    end
  end

  // Drive one request until accepted; expected result goes to the scoreboard at the accept edge.
  task automatic send(input logic [2:0] s, input logic [31:0] b, input logic [15:0] im,
                      input logic fv, input logic [31:0] fd, input logic [31:0] eop);
    bit   done = 0;
    exp_t e;
    e.op  = eop;
    e.err = (s >= 3'd6);
    in_valid = 1'b1;
    sel      = s;
    b_in     = b;
    imm      = im;
`ifdef ALU_SRC_B_FWD_EN
    fwd_valid = fv;
    fwd_data  = fd;
`endif
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      if (done) begin
        q.push_back(e);
        if (e.err && model_cnt < 255) model_cnt++;
      end
      #1;
    end
    in_valid = 1'b0;
`ifdef ALU_SRC_B_FWD_EN
    fwd_valid = 1'b0;
`endif
    if (!done) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got no accept want accept sel=%0d", s);
    end
  endtask

  task automatic wait_empty();
    for (int k = 0; k < 300 && q.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", q.size());
    end
  endtask

  initial begin
    logic [2:0]  rs;
    logic [31:0] rb, rfd;
    logic [15:0] ri;
    logic        rfv;

    // Requests during reset must be ignored.
    reset = 1'b0; in_valid = 1'b1; sel = 3'd1; ready_mode = 1;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    reset = 1'b1;

    send(3'd1, 32'h1234_5678, 16'h00ff, 1'b0, 32'd0, 32'h4);
    send(3'd2, 32'd0, 16'h8001, 1'b0, 32'd0, 32'h8001_0000);
    send(3'd3, 32'd0, 16'h8001, 1'b0, 32'd0, 32'hFFFE_0004);
    send(3'd4, 32'd0, 16'h8001, 1'b0, 32'd0, 32'hFFFF_8001);
    send(3'd5, 32'd0, 16'h8001, 1'b0, 32'd0, 32'h0000_8001);
    send(3'd3, 32'd0, 16'h7fff, 1'b0, 32'd0, 32'h0001_FFFC);
    wait_empty();

    // Back-pressure: two accepted, third stalls until the ALU drains.
    ready_mode = 0;
    @(posedge clk); #1;
    send(3'd0, 32'd1, 16'd0, 1'b0, 32'd0, 32'd1);
    send(3'd0, 32'd2, 16'd0, 1'b0, 32'd0, 32'd2);
    in_valid = 1'b1; sel = 3'd0; b_in = 32'd3;
    @(negedge clk);
    chk("third_blocked", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    ready_mode = 1;
    send(3'd0, 32'd3, 16'd0, 1'b0, 32'd0, 32'd3);
    wait_empty();

    // Illegal selects: zero operand, flagged, counter saturates.
    for (int i = 0; i < 300; i++)
      send(3'(6 + (i % 2)), $urandom, 16'($urandom), 1'b0, 32'd0, 32'd0);
    wait_empty();
    chk("err_saturated", 64'(err_cnt), 64'd255);

`ifdef ALU_SRC_B_FWD_EN
    send(3'd0, 32'd5, 16'd0, 1'b1, 32'd9, 32'd9);
    send(3'd0, 32'd5, 16'd0, 1'b0, 32'd9, 32'd5);
    ready_mode = 0;
    @(posedge clk); #1;
    send(3'd0, 32'd5, 16'd0, 1'b1, 32'd9, 32'd9);
    fwd_valid = 1'b1; fwd_data = 32'd77;
    repeat (2) @(posedge clk);
    #1;
    ready_mode = 1;
    wait_empty();
    fwd_valid = 1'b0;
`endif

    // Random traffic with random ALU stalls.
    ready_mode = 2;
    for (int i = 0; i < 400; i++) begin
      rs  = 3'($urandom_range(0, 7));
      rb  = $urandom;
      ri  = 16'($urandom);
      rfd = $urandom;
`ifdef ALU_SRC_B_FWD_EN
      rfv = 1'($urandom_range(0, 1));
`else
      rfv = 1'b0;
`endif
      send(rs, rb, ri, rfv, rfd, model(rs, rb, ri, rfv, rfd));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    ready_mode = 1;
    wait_empty();

    // Asynchronous reset with both entries full.
    ready_mode = 0;
    @(posedge clk); #1;
    send(3'd0, 32'd11, 16'd0, 1'b0, 32'd0, 32'd11);
    send(3'd0, 32'd22, 16'd0, 1'b0, 32'd0, 32'd22);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_out_valid", 64'(out_valid), 64'd0);
    chk("async_rst_operand", 64'(operand), 64'd0);
    chk("async_rst_in_ready", 64'(in_ready), 64'd1);
    q.delete();
    model_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    ready_mode = 1;
    repeat (6) @(posedge clk);
    #1;
    send(3'd1, 32'd0, 16'd0, 1'b0, 32'd0, 32'h4);
    wait_empty();
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_src_b_stage.md
# alu_src_b_stage

Registered, parametrised successor to the ALU operand-B selector in the multicycle datapath. Selects operand B from the B register, an increment constant, or one of four immediate transforms; width and constant are parametrised, and illegal selects are flagged and counted. The result sits in a two-entry skid buffer with valid/ready handshakes on both sides, between the register-read/immediate stage and the ALU, so ALU stalls never drop an operand.

## Interface
- WIDTH, 32, operand width; legal range 18..64.
- IMM_W, 16, immediate field width; must be less than WIDTH-2.
- INC, 4, constant driven on select 1 (PC increment), truncated to WIDTH.
- ERR_W, 8, width of the illegal-select counter.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- in_valid  in  1  upstream request carries a valid sel/b_in/imm.
- in_ready  out  1  stage can accept this cycle.
- sel  in  3  operand-B mode, encoding under Operation.
- b_in  in  WIDTH  B register value.
- imm  in  IMM_W  instruction immediate field.
- fwd_valid  in  1  forward data valid (present only with ALU_SRC_B_FWD_EN).
- fwd_data  in  WIDTH  forwarded write-back value (present only with ALU_SRC_B_FWD_EN).
- out_valid  out  1  operand holds a valid result.
- out_ready  in  1  ALU consumes the operand this cycle.
- operand  out  WIDTH  selected operand B.
- sel_err  out  1  the operand at the head was produced from an illegal sel.
- err_cnt  out  ERR_W  saturating count of accepted illegal selects.

## Operation
- Select encoding: 0 b_in; 1 INC; 2 imm << 16, low 16 bits zero, truncated to WIDTH; 3 sign-extended imm << 2; 4 sign-extended imm; 5 zero-extended imm; 6 and 7 illegal, operand = 0, sel_err = 1.
- Sign extension replicates imm[IMM_W-1] to WIDTH. The shift in mode 3 is applied after extension. Bits shifted past WIDTH-1 are discarded.
- Result and sel_err are computed combinationally at input and captured only on accept (in_valid && in_ready).
- Buffer occupancy states:
  - EMPTY: out_valid = 0.
  - ONE: head valid.
  - TWO: head valid plus skid entry.
- in_ready = (state != TWO). It is a direct register decode with no combinational path from out_ready.
- Transitions (acc = accept, pop = out_valid && out_ready):
  - EMPTY --acc--> ONE.
  - ONE --acc && !pop--> TWO, and the new result goes to the skid entry.
  - ONE --acc && pop--> ONE, and the head is replaced.
  - ONE --pop only--> EMPTY.
  - TWO --pop--> ONE, and the skid entry moves to head. No accept is possible in TWO.
- Ordering is strictly FIFO. Head operand and sel_err hold stable while out_valid && !out_ready.
- err_cnt increments once per accepted illegal sel and saturates at all-ones. Rejected requests are not counted.

## Timing
- Latency: accept at edge N gives out_valid and operand valid after edge N, when entering from EMPTY.
- Throughput: one operand per cycle while out_ready = 1.
- While reset is low:
  - state = EMPTY, out_valid = 0, operand = 0, sel_err = 0, err_cnt = 0, skid entry = 0.
  - in_ready = 1, but inputs are ignored.
- Reset mid-operation discards both entries immediately (asynchronous). No operand is emitted afterwards.
- Simultaneous accept and pop in ONE is lossless and keeps the stage full at one entry.
- Illegal sel does not block the handshake. The entry flows normally with operand 0.

## Configuration
- ALU_SRC_B_FWD_EN defined: fwd_valid/fwd_data ports exist. On select 0, if fwd_valid = 1 at accept, fwd_data replaces b_in. The forward value is captured at accept only; a later fwd_valid does not alter buffered entries.
- ALU_SRC_B_FWD_EN undefined: the ports are absent and select 0 always uses b_in.

## Structure
- Shared package alu_src_b_pkg:
  - select-code constants: SEL_B, SEL_INC, SEL_LUI, SEL_BR, SEL_SEXT, SEL_ZEXT.
  - 2-bit occupancy state typedef: EMPTY, ONE, TWO.
- One sub-module, alu_src_b_sel: purely combinational; produces the result and illegal flag from sel/b_in/imm (and fwd inputs when enabled).
- The top holds the skid buffer, state machine and counter.

## Test plan
- Reset low for 3 cycles while driving in_valid=1, sel=1 → out_valid=0, err_cnt=0. After release, first accept yields operand=32'h4 one cycle later.
- Imm 16'h8001, WIDTH=32:
  - sel 2 → 32'h80010000.
  - sel 3 → 32'hFFFE0004.
  - sel 4 → 32'hFFFF8001.
  - sel 5 → 32'h00008001.
- out_ready=0, three back-to-back requests b_in=1,2,3 → accepts 1 and 2, in_ready=0 on the third. Then out_ready=1 → outputs 1,2,3 in order, none lost or duplicated.
- sel=7 accepted 300 times with ERR_W=8 → each output operand=0 with sel_err=1; err_cnt saturates at 255.
- With ALU_SRC_B_FWD_EN: sel 0, b_in=5, fwd_valid=1, fwd_data=9 → operand=9. With fwd_valid=0 → operand=5.
- Assert reset in state TWO → out_valid falls immediately. After release, no stale operand appears.
